// File: rtl/mem_addr_gen_pkg.sv
// Shared configuration and types for the affine address generator.
package mem_addr_gen_pkg;

    localparam int unsigned NUM_DIMS    = 6;
    localparam int unsigned ADDR_WIDTH  = 16;
    localparam int unsigned RANGE_WIDTH = 32;
    localparam int unsigned DIM_W       = 3;

    typedef enum logic {
        IDLE,
        RUN
    } addr_gen_state_t;

    typedef logic [NUM_DIMS-1:0][ADDR_WIDTH-1:0]  stride_arr_t;
    typedef logic [NUM_DIMS-1:0][RANGE_WIDTH-1:0] range_arr_t;

    // Zero dimensions behaves as one loop; anything beyond NUM_DIMS is clamped.
    function automatic logic [DIM_W-1:0] eff_dims(input logic [3:0] d);
        if (d == '0)
            return DIM_W'(1);
        else if (d > 4'(NUM_DIMS))
            return DIM_W'(NUM_DIMS);
        else
            return d[DIM_W-1:0];
    endfunction

endpackage

// File: rtl/addr_gen_dim.sv
// One loop level: trip counter plus incrementally maintained offset cnt*stride.
module addr_gen_dim #(
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned RANGE_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   inc,
    input  logic                   active,
    input  logic [RANGE_WIDTH-1:0] range,
    input  logic [ADDR_WIDTH-1:0]  stride,
    output logic                   at_max,
    output logic [ADDR_WIDTH-1:0]  off
);

    logic [RANGE_WIDTH-1:0] cnt;
    logic                   last;

    // A range of 0 or 1 means the counter is always at its final value.
    assign last   = (range <= RANGE_WIDTH'(1)) || (cnt == range - RANGE_WIDTH'(1));
    // Inactive levels report at_max so they pass the carry straight through.
    assign at_max = !active || last;

    // Counter/offset update: clear has priority, then wrap-or-increment on inc.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            off <= '0;
        end else if (clear) begin
            cnt <= '0;
            off <= '0;
        end else if (inc && active) begin
            if (last) begin
                cnt <= '0;
                off <= '0;
            end else begin
                cnt <= cnt + RANGE_WIDTH'(1);
                off <= off + stride;
            end
        end
    end

endmodule

// File: rtl/mem_addr_gen.sv
// Affine multi-dimensional address generator feeding memory_core addr_in/ren_in.
module mem_addr_gen
    import mem_addr_gen_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clk_en,
    input  logic                   flush,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  starting_addr,
    input  logic [3:0]             dimensionality,
    input  logic [ADDR_WIDTH-1:0]  stride_0,
    input  logic [ADDR_WIDTH-1:0]  stride_1,
    input  logic [ADDR_WIDTH-1:0]  stride_2,
    input  logic [ADDR_WIDTH-1:0]  stride_3,
    input  logic [ADDR_WIDTH-1:0]  stride_4,
    input  logic [ADDR_WIDTH-1:0]  stride_5,
    input  logic [RANGE_WIDTH-1:0] range_0,
    input  logic [RANGE_WIDTH-1:0] range_1,
    input  logic [RANGE_WIDTH-1:0] range_2,
    input  logic [RANGE_WIDTH-1:0] range_3,
    input  logic [RANGE_WIDTH-1:0] range_4,
    input  logic [RANGE_WIDTH-1:0] range_5,
    input  logic                   step,
    output logic [ADDR_WIDTH-1:0]  addr_out,
    output logic                   addr_valid,
    output logic                   done,
    output logic [RANGE_WIDTH-1:0] addr_count
);

    stride_arr_t            stride_in;
    stride_arr_t            stride_q;
    range_arr_t             range_in;
    range_arr_t             range_q;
    stride_arr_t            off;
    logic [DIM_W-1:0]       dims_q;
    logic [ADDR_WIDTH-1:0]  start_q;
    addr_gen_state_t        state;
    logic                   done_q;
    logic [RANGE_WIDTH-1:0] count_q;

    logic [NUM_DIMS:0]      carry;
    logic [NUM_DIMS-1:0]    at_max;
    logic [NUM_DIMS-1:0]    active;
    logic                   accept;
    logic                   start_en;
    logic                   last_step;
    logic                   clear;
    logic [ADDR_WIDTH-1:0]  addr_sum;

    assign stride_in = {stride_5, stride_4, stride_3, stride_2, stride_1, stride_0};
    assign range_in  = {range_5, range_4, range_3, range_2, range_1, range_0};

    assign accept    = (state == RUN) && step && clk_en;
    assign start_en  = start && clk_en;
    assign carry[0]  = accept;
    assign last_step = carry[NUM_DIMS];
    // Counters restart on flush, a new start, or completion of the walk.
    assign clear     = flush || start_en || last_step;

    for (genvar i = 0; i < NUM_DIMS; i++) begin : g_dim
        assign active[i]  = DIM_W'(i) < dims_q;
        assign carry[i+1] = carry[i] & at_max[i];

        addr_gen_dim #(
            .ADDR_WIDTH  (ADDR_WIDTH),
            .RANGE_WIDTH (RANGE_WIDTH)
        ) u_dim (
            .clk    (clk),
            .reset  (reset),
            .clear  (clear),
            .inc    (carry[i]),
            .active (active[i]),
            .range  (range_q[i]),
            .stride (stride_q[i]),
            .at_max (at_max[i]),
            .off    (off[i])
        );
    end

    // Address is the base plus all level offsets, wrapping modulo 2^ADDR_WIDTH.
    always_comb begin
        addr_sum = start_q;
        for (int unsigned i = 0; i < NUM_DIMS; i++) begin
            addr_sum = addr_sum + off[i];
        end
    end

    assign addr_out   = addr_sum;
    assign addr_valid = (state == RUN);
    assign done       = done_q;
    assign addr_count = count_q;

    // Walk control: flush beats start, restart beats completion, clk_en freezes all.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            done_q   <= 1'b0;
            count_q  <= '0;
            start_q  <= '0;
            dims_q   <= '0;
            stride_q <= '0;
            range_q  <= '0;
        end else if (flush) begin
            state   <= IDLE;
            done_q  <= 1'b0;
            count_q <= '0;
        end else if (clk_en) begin
            done_q <= 1'b0;
            if (start) begin
                state    <= RUN;
                count_q  <= '0;
                start_q  <= starting_addr;
                dims_q   <= eff_dims(dimensionality);
                stride_q <= stride_in;
                range_q  <= range_in;
            end else if (last_step) begin
                state   <= IDLE;
                done_q  <= 1'b1;
                count_q <= count_q + RANGE_WIDTH'(1);
            end else if (accept) begin
                count_q <= count_q + RANGE_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_addr_gen.sv
// Directed self-checking bench for mem_addr_gen.
module tb_mem_addr_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_en;
    logic        flush;
    logic        start;
    logic [15:0] starting_addr;
    logic [3:0]  dimensionality;
    logic [15:0] stride_0, stride_1, stride_2, stride_3, stride_4, stride_5;
    logic [31:0] range_0, range_1, range_2, range_3, range_4, range_5;
    logic        step;
    logic [15:0] addr_out;
    logic        addr_valid;
    logic        done;
    logic [31:0] addr_count;

    int unsigned errors = 0;
    int unsigned checks = 0;
    logic [15:0] exp_q[$];

    mem_addr_gen dut (
        .clk            (clk),
        .reset          (reset),
        .clk_en         (clk_en),
        .flush          (flush),
        .start          (start),
        .starting_addr  (starting_addr),
        .dimensionality (dimensionality),
        .stride_0       (stride_0),
        .stride_1       (stride_1),
        .stride_2       (stride_2),
        .stride_3       (stride_3),
        .stride_4       (stride_4),
        .stride_5       (stride_5),
        .range_0        (range_0),
        .range_1        (range_1),
        .range_2        (range_2),
        .range_3        (range_3),
        .range_4        (range_4),
        .range_5        (range_5),
        .step           (step),
        .addr_out       (addr_out),
        .addr_valid     (addr_valid),
        .done           (done),
        .addr_count     (addr_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cfg(input logic [15:0] sa, input logic [3:0] d,
                       input logic [15:0] s0, input logic [15:0] s1, input logic [15:0] s2,
                       input logic [31:0] r0, input logic [31:0] r1, input logic [31:0] r2);
        starting_addr  = sa;
        dimensionality = d;
        stride_0 = s0; stride_1 = s1; stride_2 = s2;
        stride_3 = '0; stride_4 = '0; stride_5 = '0;
        range_0  = r0; range_1  = r1; range_2  = r2;
        range_3  = '0; range_4  = '0; range_5  = '0;
    endtask

    // Pulse start for one cycle; returns at the negedge where the first address shows.
    task automatic start_walk();
        @(negedge clk);
        start = 1'b1;
        step  = 1'b0;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Hold step high through the expected address list, then check completion.
    task automatic walk_check(input string name);
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s_addr%0d", name, i), 32'(addr_out), 32'(exp_q[i]));
            check($sformatf("%s_valid%0d", name, i), 32'(addr_valid), 32'd1);
            check($sformatf("%s_nodone%0d", name, i), 32'(done), 32'd0);
            step = 1'b1;
            @(negedge clk);
        end
        step = 1'b0;
        check({name, "_valid_end"}, 32'(addr_valid), 32'd0);
        check({name, "_done"}, 32'(done), 32'd1);
        check({name, "_count"}, addr_count, 32'(exp_q.size()));
        @(negedge clk);
        check({name, "_done_once"}, 32'(done), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; clk_en = 1'b1; flush = 1'b0; start = 1'b0; step = 1'b0;
        cfg(16'h0, 4'd0, '0, '0, '0, '0, '0, '0);
        @(negedge clk);
        check("rst_addr",  32'(addr_out),   32'd0);
        check("rst_valid", 32'(addr_valid), 32'd0);
        check("rst_done",  32'(done),       32'd0);
        check("rst_count", addr_count,      32'd0);
        reset = 1'b0;

        // 3x3x3 walk with strides 1,3,9 gives the linear index 0..26
        cfg(16'h0000, 4'd3, 16'd1, 16'd3, 16'd9, 32'd3, 32'd3, 32'd3);
        start_walk();
        exp_q = {};
        for (int k = 0; k < 27; k++) exp_q.push_back(16'(k));
        walk_check("cube");

        // 2x3 walk; inputs changed after start must not matter
        cfg(16'h0010, 4'd2, 16'd4, 16'd100, 16'd0, 32'd2, 32'd3, 32'd0);
        start_walk();
        stride_0 = 16'd7; stride_1 = 16'd1; range_0 = 32'd9; starting_addr = 16'h0555;
        exp_q = {16'h0010, 16'h0014, 16'h0074, 16'h0078, 16'h00D8, 16'h00DC};
        walk_check("rect");

        // Modulo wrap of the address sum
        cfg(16'h0001, 4'd1, 16'hFFFF, 16'd0, 16'd0, 32'd3, 32'd0, 32'd0);
        start_walk();
        exp_q = {16'h0001, 16'h0000, 16'hFFFF};
        walk_check("wrap");

        // Flush mid-walk after five accepts
        cfg(16'h0000, 4'd3, 16'd1, 16'd3, 16'd9, 32'd3, 32'd3, 32'd3);
        start_walk();
        step = 1'b1;
        repeat (5) @(negedge clk);
        check("fl_addr5",  32'(addr_out), 32'd5);
        check("fl_count5", addr_count,    32'd5);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        step  = 1'b0;
        check("fl_valid", 32'(addr_valid), 32'd0);
        check("fl_done",  32'(done),       32'd0);
        starting_addr = 16'h0200;
        start_walk();
        check("fl_restart_addr",  32'(addr_out), 32'h200);
        check("fl_restart_count", addr_count,    32'd0);

        // clk_en gating with step held high
        step = 1'b1; clk_en = 1'b1;
        @(negedge clk);
        check("en1_addr", 32'(addr_out), 32'h201);
        clk_en = 1'b0;
        @(negedge clk);
        check("en0_addr", 32'(addr_out), 32'h201);
        clk_en = 1'b1;
        @(negedge clk);
        check("en1b_addr", 32'(addr_out), 32'h202);
        check("en1b_count", addr_count, 32'd2);
        clk_en = 1'b0;
        @(negedge clk);
        check("en0b_addr", 32'(addr_out), 32'h202);

        // Asynchronous reset between clock edges
        #2 reset = 1'b1;
        #1;
        check("arst_addr",  32'(addr_out),   32'd0);
        check("arst_valid", 32'(addr_valid), 32'd0);
        check("arst_count", addr_count,      32'd0);
        @(negedge clk);
        reset = 1'b0; clk_en = 1'b1; step = 1'b0;

        // Zero dims and zero range: single address, done held while clk_en low
        cfg(16'h1234, 4'd0, 16'd3, 16'd0, 16'd0, 32'd0, 32'd0, 32'd0);
        start_walk();
        check("one_addr",  32'(addr_out),   32'h1234);
        check("one_valid", 32'(addr_valid), 32'd1);
        step = 1'b1; stride_0 = 16'd5;
        @(negedge clk);
        step = 1'b0;
        check("one_valid_end", 32'(addr_valid), 32'd0);
        check("one_done",      32'(done),       32'd1);
        check("one_count",     addr_count,      32'd1);
        clk_en = 1'b0;
        @(negedge clk);
        check("one_done_frozen", 32'(done), 32'd1);
        clk_en = 1'b1;
        @(negedge clk);
        check("one_done_clear", 32'(done), 32'd0);

        // Start coinciding with the final step: restart wins, no done
        cfg(16'h0040, 4'd1, 16'd1, 16'd0, 16'd0, 32'd1, 32'd0, 32'd0);
        start_walk();
        check("rs_addr", 32'(addr_out), 32'h40);
        starting_addr = 16'h0080;
        start = 1'b1; step = 1'b1;
        @(negedge clk);
        start = 1'b0; step = 1'b0;
        check("rs_new_addr", 32'(addr_out),   32'h80);
        check("rs_valid",    32'(addr_valid), 32'd1);
        check("rs_nodone",   32'(done),       32'd0);
        check("rs_count",    addr_count,      32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_addr_gen.md
Name: mem_addr_gen

Overview:
- Affine multi-dimensional address generator directly upstream of memory_core; drives its addr_in and ren_in.
- Walks up to 6 nested loops: address = starting_addr + sum(cnt_i * stride_i), one address per accepted step.
- Uses the same stride/range/dimensionality/starting_addr configuration the memory core tile sees, so formal harnesses can share one configuration assumption.

Parameters:
- NUM_DIMS, 6, number of loop levels.
- ADDR_WIDTH, 16, address and stride width.
- RANGE_WIDTH, 32, loop-bound width.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- clk_en  input  1  global clock enable; state advances only when high.
- flush  input  1  synchronous restart to IDLE; acts regardless of clk_en.
- start  input  1  pulse; latches config and begins a walk.
- starting_addr  input  ADDR_WIDTH  base address.
- dimensionality  input  4  number of active loops; 0 is treated as 1, values above NUM_DIMS are clamped.
- stride_0..stride_5  input  ADDR_WIDTH  per-loop increment.
- range_0..range_5  input  RANGE_WIDTH  per-loop trip count; 0 is treated as 1.
- step  input  1  consumer accepts the current address.
- addr_out  output  ADDR_WIDTH  current address, driven to memory_core.addr_in.
- addr_valid  output  1  addr_out is meaningful; drives ren_in through the parent.
- done  output  1  one-cycle pulse after the last address is accepted.
- addr_count  output  RANGE_WIDTH  number of addresses accepted in the current walk.

Behaviour:
- Reset (async): state=IDLE; all counters and offsets 0; addr_out=0, addr_valid=0, done=0, addr_count=0.
- FSM states are IDLE, RUN.
  - IDLE -> RUN on start&clk_en.
  - RUN -> IDLE on the final accepted step (done=1 that cycle+1, i.e. registered).
  - RUN -> RUN (restart) on start&clk_en.
  - Any state -> IDLE on flush.
- Start:
  - Latches starting_addr, strides, ranges and effective dimensionality into shadow registers.
  - Clears cnt_i, off_i and addr_count.
  - Input config changes after start have no effect until the next start.
- Address:
  - addr_out = start_q + sum(off_i), where off_i = cnt_i*stride_i kept incrementally.
  - Sum is modulo 2^ADDR_WIDTH; wrap-around is silent.
  - addr_out and addr_valid are registered-state combinational outputs, so the first address is valid the cycle after start.
- Step is accepted when state==RUN && step && clk_en.
  - cnt_0++ and off_0 += stride_0.
  - If cnt_0 was range_0-1, instead set cnt_0=0, off_0=0 and carry into level 1, rippling upward.
  - Levels >= effective dimensionality never change.
  - addr_count increments on each accept.
- Last address: all active cnt_i == range_i-1 at accept.
  - Next cycle: state=IDLE, addr_valid=0, done=1 for exactly one cycle.
  - Counters return to 0.
- step in IDLE or with clk_en=0 is ignored; step with addr_valid=0 is a protocol no-op.
- start and flush in the same cycle: flush wins.
- start on the same cycle as the final step: restart wins, and done is not pulsed.
- clk_en=0 freezes all state, including the done pulse timing (done stays asserted until the next enabled cycle).
- Arithmetic: counters are RANGE_WIDTH wide; offsets are ADDR_WIDTH wide with truncating adds.
- Total addresses per walk = product of active ranges; callers keep this within 2^RANGE_WIDTH.

Decomposition:
- Shared package mem_addr_gen_pkg holds:
  - NUM_DIMS, ADDR_WIDTH, RANGE_WIDTH;
  - enum addr_gen_state_t {IDLE, RUN};
  - stride_arr_t / range_arr_t packed-array typedefs.
- One sub-module, addr_gen_dim: a single loop level holding cnt/off with inputs inc, active, range, stride and outputs at_max, off.
  - Instantiate NUM_DIMS times in a generate loop; carry_i+1 = carry_i & at_max_i.

Test Plan:
- dims=3, strides 1,3,9, ranges 3,3,3, start_addr 0, step held high → addr_out 0,1,...,26 on consecutive cycles; done pulses once; addr_count=27; addr_valid drops after 26.
- dims=2, strides 4,100, ranges 2,3, start_addr 0x0010 → sequence 0x10,0x14,0x74,0x78,0xD8,0xDC, then done.
- dims=1, stride 0xFFFF, range 3, start_addr 1 → 1,0,0xFFFF (modulo wrap), done.
- Mid-walk, after 5 accepts with step held: flush → next cycle IDLE, addr_valid=0, no done. Then start → addr_out=starting_addr, addr_count=0.
- clk_en toggling 1,0,1,0 with step high → address advances only on enabled cycles. Assert reset asynchronously mid-walk → outputs 0 immediately, without waiting for a clock edge.
- dimensionality=0, range_0=0 → treated as 1 → single address = starting_addr, then done. Changing stride_0 during RUN → sequence unaffected.
